tmp_open_list_queue: RTL and testbench
======================================

// Module: tmp_open_list_queue
// PURPOSE
//  Min-first priority queue for the open list of a path-search engine, built as a systolic array.
//  Accepts enqueue, dequeue and replace (dequeue+enqueue) commands.
//  Always presents the smallest stored f-value on o_node_f.
//  Sits between the node expander (producer) and the node selector (consumer).
// PARAMETERS
//  QUEUE_SIZE  4   number of systolic cells; each cell holds 2 entries -> capacity 2*QUEUE_SIZE
//  DATA_WIDTH  32  width of the f-value key (unsigned)
// PORTS
//  CLK       in   1           single clock, all logic on posedge
//  RSTn      in   1           reset, synchronous, active-low
//  i_wrt     in   1           enqueue i_node_f this cycle
//  i_read    in   1           dequeue current minimum this cycle (with i_wrt = replace)
//  i_node_f  in   DATA_WIDTH  key to insert
//  o_full    out  1           queue holds 2*QUEUE_SIZE entries
//  o_empty   out  1           queue holds 0 entries
//  o_node_f  out  DATA_WIDTH  current minimum key
// BEHAVIOUR
//  - Reset: all slots = sentinel '1 (all ones), count=0, o_empty=1, o_full=0, o_node_f='1.
//  - Keys unsigned; the sentinel '1 means empty slot; host keys must be < '1.
//  - Ordering:
//    - Cell 0 holds the global minimum.
//    - Each cell keeps its pair sorted (lo<=hi).
//    - Every key in cell k <= every key in cell k+1 once the array has settled.
//  - Enqueue (i_wrt & !i_read & !o_full):
//    - Key enters cell 0 and is compared there.
//    - The displaced max ripples one cell per cycle toward cell QUEUE_SIZE-1.
//    - count+1.
//  - Dequeue (i_read & !i_wrt & !o_empty):
//    - Cell 0 lo is removed.
//    - The hole is refilled from cell k+1 one cell per cycle; the sentinel enters at the tail.
//    - count-1.
//  - Replace (i_wrt & i_read):
//    - If not empty: the min is removed and i_node_f inserted in the same edge; count unchanged.
//    - If empty: behaves as an enqueue.
//  - Ignored commands, with no state change:
//    - Enqueue when full; the new key is discarded.
//    - Dequeue when empty.
//  - Latency:
//    - o_node_f, o_full and o_empty reflect a command on the clock edge that samples it (1 cycle).
//    - Internal ripple completes within QUEUE_SIZE cycles.
//  - Throughput: one command per 2 cycles; the host inserts at least 1 idle cycle between commands.
//  - Flags: o_full = (count==2*QUEUE_SIZE), o_empty = (count==0), both registered.
//  - Reset mid-operation: in-flight ripples are discarded; state returns to the reset values above.
// CONFIGURATION
//  OPEN_LIST_ASSERT_EN defined:
//    - Simulation assertions are compiled in: enqueue when full, dequeue when empty, back-to-back commands.
//    - Each assertion reports via $error.
//    - The sorted invariant between adjacent cells is checked every idle cycle.
//  OPEN_LIST_ASSERT_EN undefined: no checkers are compiled; RTL behaviour is identical.
// STRUCTURE
//  - Package open_list_pkg: typedef logic [DATA_WIDTH-1:0] key_t, constant KEY_EMPTY = '1, op enum {NOP,PUSH,POP,REPLACE}.
//  - Sub-module open_list_cell:
//    - One systolic cell holding 2 keys plus a pending-op register.
//    - Takes an incoming op/key from the upstream cell.
//    - Returns a key to the upstream cell and forwards an op/key to the downstream cell.
//  - Top: a generate loop of QUEUE_SIZE cells, a count register and flag logic.
// TESTING
//  - Reset, then idle -> o_empty=1, o_full=0, o_node_f='1.
//  - Enqueue 500,20,700,20,9,1000,300,64 with 3 idle cycles each:
//    - o_node_f min trace is 500,20,20,20,9,9,9,9.
//    - o_full=1 after the 8th enqueue.
//  - Enqueue 5 when full -> ignored; o_node_f=9, o_full stays 1.
//  - Dequeue 8 times -> o_node_f sequence 20,20,64,300,500,700,1000,'1; o_empty=1 at the end.
//  - Load 10,30,50; replace with 40 -> o_node_f=30; replace with 5 -> 5; count stays 3.
//  - Random stress, 100 mixed commands over keys 0..1024 vs a sorted reference model:
//    - o_node_f equals the reference minimum after every command.
//    - Flags match the reference count.

Source files
------------

// File: rtl/open_list_pkg.sv
// Shared types for the open-list priority queue: key type, empty-slot sentinel and cell op codes.
package open_list_pkg;
  localparam int KEY_WIDTH = 32;
  typedef logic [KEY_WIDTH-1:0] key_t;
  localparam key_t KEY_EMPTY = '1;
  typedef enum logic [1:0] {NOP, PUSH, POP, REPLACE} op_t;
endpackage

// File: rtl/open_list_cell.sv
// One systolic cell: a sorted key pair plus the op/key it forwards downstream next cycle.
// Applies the incoming op in one cycle; reads the downstream lo combinationally to refill on POP/REPLACE.
module open_list_cell
  import open_list_pkg::*;
#(
  parameter int DATA_WIDTH = KEY_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  op_t                   i_op,
  input  logic [DATA_WIDTH-1:0] i_key,
  input  logic [DATA_WIDTH-1:0] i_next_lo,
  output logic [DATA_WIDTH-1:0] o_lo,
  output op_t                   o_op,
  output logic [DATA_WIDTH-1:0] o_key
);

  logic [DATA_WIDTH-1:0] r_lo, r_hi, r_key;
  op_t                   r_op;

  logic [DATA_WIDTH-1:0] w_lo_nxt, w_hi_nxt, w_key_nxt, w_small, w_large;
  op_t                   w_op_nxt;

  always_comb begin
    w_lo_nxt  = r_lo;
    w_hi_nxt  = r_hi;
    w_key_nxt = '1;
    w_op_nxt  = NOP;
    w_small   = (i_key < r_hi) ? i_key : r_hi;
    w_large   = (i_key < r_hi) ? r_hi : i_key;
    case (i_op)
      PUSH: begin
        if (i_key < r_lo) begin
          w_lo_nxt  = i_key;
          w_hi_nxt  = r_lo;
          w_key_nxt = r_hi;
        end else if (i_key < r_hi) begin
          w_hi_nxt  = i_key;
          w_key_nxt = r_hi;
        end else begin
          w_key_nxt = i_key;
        end
        // Pushing a sentinel further down changes nothing, so stop the wave here.
        w_op_nxt = (&w_key_nxt) ? NOP : PUSH;
      end
      POP: begin
        w_lo_nxt = r_hi;
        w_hi_nxt = i_next_lo;
        w_op_nxt = POP;
      end
      REPLACE: begin
        // The downstream cell only needs to act if the larger survivor overtakes its lo.
        w_lo_nxt = w_small;
        if (w_large <= i_next_lo) begin
          w_hi_nxt = w_large;
        end else begin
          w_hi_nxt  = i_next_lo;
          w_op_nxt  = REPLACE;
          w_key_nxt = w_large;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_lo  <= '1;
      r_hi  <= '1;
      r_op  <= NOP;
      r_key <= '1;
    end else begin
      r_lo  <= w_lo_nxt;
      r_hi  <= w_hi_nxt;
      r_op  <= w_op_nxt;
      r_key <= w_key_nxt;
    end
  end

  assign o_lo  = r_lo;
  assign o_op  = r_op;
  assign o_key = r_key;

`ifdef OPEN_LIST_ASSERT_EN
  always_ff @(posedge CLK) begin
    if (RSTn && i_op == NOP) begin
      if (r_lo > r_hi)      $error("open_list_cell: pair out of order lo=%0d hi=%0d", r_lo, r_hi);
      if (r_hi > i_next_lo) $error("open_list_cell: hi=%0d above next cell lo=%0d", r_hi, i_next_lo);
    end
  end
`endif

endmodule

// File: rtl/tmp_open_list_queue.sv
// Min-first systolic open list; o_node_f/o_full/o_empty update on the edge that takes a command.
// Host spaces commands by >=1 idle cycle; OPEN_LIST_ASSERT_EN compiles in usage/ordering checkers.
module tmp_open_list_queue
  import open_list_pkg::*;
#(
  parameter int QUEUE_SIZE = 4,
  parameter int DATA_WIDTH = KEY_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_node_f,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_node_f
);

  localparam int CNT_W = $clog2(2*QUEUE_SIZE+1);

  op_t                   w_op  [QUEUE_SIZE+1];
  logic [DATA_WIDTH-1:0] w_key [QUEUE_SIZE+1];
  logic [DATA_WIDTH-1:0] w_lo  [QUEUE_SIZE+1];

  op_t              w_cmd_op;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_full, r_empty;

  // Replace on an empty queue degenerates to a plain enqueue.
  always_comb begin
    w_cmd_op    = NOP;
    w_count_nxt = r_count;
    if (i_wrt && i_read && !r_empty) begin
      w_cmd_op = REPLACE;
    end else if (i_wrt && !r_full) begin
      w_cmd_op    = PUSH;
      w_count_nxt = r_count + CNT_W'(1);
    end else if (i_read && !i_wrt && !r_empty) begin
      w_cmd_op    = POP;
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  assign w_op[0]           = w_cmd_op;
  assign w_key[0]          = i_node_f;
  assign w_lo[QUEUE_SIZE]  = '1;

  for (genvar k = 0; k < QUEUE_SIZE; k++) begin : g_cell
    open_list_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .i_op      (w_op[k]),
      .i_key     (w_key[k]),
      .i_next_lo (w_lo[k+1]),
      .o_lo      (w_lo[k]),
      .o_op      (w_op[k+1]),
      .o_key     (w_key[k+1])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(2*QUEUE_SIZE));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_full   = r_full;
  assign o_empty  = r_empty;
  assign o_node_f = w_lo[0];

`ifdef OPEN_LIST_ASSERT_EN
  logic r_cmd_d;
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_cmd_d <= 1'b0;
    end else begin
      r_cmd_d <= i_wrt || i_read;
      if (i_wrt && !i_read && r_full)  $error("open_list: enqueue while full");
      if (i_read && !i_wrt && r_empty) $error("open_list: dequeue while empty");
      if (r_cmd_d && (i_wrt || i_read)) $error("open_list: back-to-back commands");
    end
  end
`endif

endmodule

// File: tb/tb_tmp_open_list_queue.sv
// Bench for tmp_open_list_queue: directed min-trace scenarios plus randomized commands vs a sorted-queue model.
module tb_tmp_open_list_queue;
  localparam int          QS   = 4;
  localparam int          CAP  = 2*QS;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        i_wrt = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_node_f = '0;
  logic        o_full, o_empty;
  logic [31:0] o_node_f;

  int checks = 0;
  int failures = 0;
  logic [31:0] model[$];

  tmp_open_list_queue #(.QUEUE_SIZE(QS), .DATA_WIDTH(32)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .i_wrt    (i_wrt),
    .i_read   (i_read),
    .i_node_f (i_node_f),
    .o_full   (o_full),
    .o_empty  (o_empty),
    .o_node_f (o_node_f)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model_min();
    return (model.size() > 0) ? model[0] : SENT;
  endfunction

  // Drives one command for a single edge, then returns on the following negedge with the model updated.
  task automatic cmd(input logic w, input logic r, input logic [31:0] k, input int idle);
    repeat (idle) @(negedge CLK);
    @(negedge CLK);
    i_wrt = w; i_read = r; i_node_f = k;
    @(negedge CLK);
    i_wrt = 1'b0; i_read = 1'b0;
    if (w && r && model.size() > 0) begin
      void'(model.pop_front());
      model.push_back(k);
      model.sort();
    end else if (w && model.size() < CAP) begin
      model.push_back(k);
      model.sort();
    end else if (r && !w && model.size() > 0) begin
      void'(model.pop_front());
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    model.delete();
    repeat (2) @(negedge CLK);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", o_empty); end
    checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", o_full); end
    checks++; if (o_node_f !== SENT) begin failures++; $display("FAIL reset_node_f got=%h want=%h", o_node_f, SENT); end
  endtask

  task automatic test_enqueue();
    logic [31:0] keys [8];
    logic [31:0] mins [8];
    keys = '{500, 20, 700, 20, 9, 1000, 300, 64};
    mins = '{500, 20, 20, 20, 9, 9, 9, 9};
    for (int i = 0; i < 8; i++) begin
      cmd(1'b1, 1'b0, keys[i], 2);
      checks++; if (o_node_f !== mins[i]) begin failures++; $display("FAIL enq_min[%0d] got=%0d want=%0d", i, o_node_f, mins[i]); end
      checks++; if (o_full !== (i == 7)) begin failures++; $display("FAIL enq_full[%0d] got=%b want=%b", i, o_full, (i == 7)); end
      checks++; if (o_empty !== 1'b0) begin failures++; $display("FAIL enq_empty[%0d] got=%b want=0", i, o_empty); end
    end
  endtask

  task automatic test_full_ignore();
    cmd(1'b1, 1'b0, 32'd5, 2);
    checks++; if (o_node_f !== 32'd9) begin failures++; $display("FAIL full_ignore_min got=%0d want=9", o_node_f); end
    checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL full_ignore_full got=%b want=1", o_full); end
  endtask

  task automatic test_dequeue();
    logic [31:0] mins [8];
    mins = '{20, 20, 64, 300, 500, 700, 1000, SENT};
    for (int i = 0; i < 8; i++) begin
      cmd(1'b0, 1'b1, 32'd0, 2);
      checks++; if (o_node_f !== mins[i]) begin failures++; $display("FAIL deq_min[%0d] got=%0d want=%0d", i, o_node_f, mins[i]); end
      checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL deq_full[%0d] got=%b want=0", i, o_full); end
    end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL deq_empty_end got=%b want=1", o_empty); end
    cmd(1'b0, 1'b1, 32'd0, 2);
    checks++; if (o_empty !== 1'b1 || o_node_f !== SENT) begin
      failures++; $display("FAIL deq_when_empty got empty=%b f=%h want empty=1 f=%h", o_empty, o_node_f, SENT);
    end
  endtask

  task automatic test_replace();
    cmd(1'b1, 1'b0, 32'd10, 2);
    cmd(1'b1, 1'b0, 32'd30, 2);
    cmd(1'b1, 1'b0, 32'd50, 2);
    cmd(1'b1, 1'b1, 32'd40, 2);
    checks++; if (o_node_f !== 32'd30) begin failures++; $display("FAIL replace40 got=%0d want=30", o_node_f); end
    cmd(1'b1, 1'b1, 32'd5, 2);
    checks++; if (o_node_f !== 32'd5) begin failures++; $display("FAIL replace5 got=%0d want=5", o_node_f); end
    checks++; if (o_full !== 1'b0 || o_empty !== 1'b0) begin
      failures++; $display("FAIL replace_flags got full=%b empty=%b want 0 0", o_full, o_empty);
    end
    cmd(1'b0, 1'b1, 32'd0, 2);
    checks++; if (o_node_f !== 32'd40) begin failures++; $display("FAIL replace_drain1 got=%0d want=40", o_node_f); end
    cmd(1'b0, 1'b1, 32'd0, 2);
    checks++; if (o_node_f !== 32'd50) begin failures++; $display("FAIL replace_drain2 got=%0d want=50", o_node_f); end
    cmd(1'b0, 1'b1, 32'd0, 2);
    checks++; if (o_empty !== 1'b1 || o_node_f !== SENT) begin
      failures++; $display("FAIL replace_drain3 got empty=%b f=%h want empty=1 f=%h", o_empty, o_node_f, SENT);
    end
  endtask

  task automatic test_reset_midflight();
    cmd(1'b1, 1'b0, 32'd100, 2);
    cmd(1'b1, 1'b0, 32'd200, 2);
    cmd(1'b1, 1'b0, 32'd300, 2);
    cmd(1'b1, 1'b0, 32'd400, 2);
    cmd(1'b1, 1'b0, 32'd50, 2);
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    model.delete();
    checks++; if (o_empty !== 1'b1 || o_full !== 1'b0 || o_node_f !== SENT) begin
      failures++; $display("FAIL midreset_state got empty=%b full=%b f=%h want 1 0 %h", o_empty, o_full, o_node_f, SENT);
    end
    cmd(1'b1, 1'b0, 32'd700, 2);
    cmd(1'b1, 1'b0, 32'd800, 2);
    checks++; if (o_node_f !== 32'd700) begin failures++; $display("FAIL midreset_push got=%0d want=700", o_node_f); end
    cmd(1'b0, 1'b1, 32'd0, 2);
    checks++; if (o_node_f !== 32'd800) begin failures++; $display("FAIL midreset_pop1 got=%0d want=800", o_node_f); end
    cmd(1'b0, 1'b1, 32'd0, 2);
    checks++; if (o_node_f !== SENT || o_empty !== 1'b1) begin
      failures++; $display("FAIL midreset_pop2 got f=%h empty=%b want f=%h empty=1", o_node_f, o_empty, SENT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 100; i++) begin
      int sel;
      logic w, r;
      sel = $urandom_range(0, 4);
      w = (sel != 2 && sel != 3);
      r = (sel >= 2);
      cmd(w, r, 32'($urandom_range(0, 1024)), $urandom_range(0, 2));
      checks++; if (o_node_f !== model_min()) begin
        failures++; $display("FAIL rand_min[%0d] got=%0d want=%0d", i, o_node_f, model_min());
      end
      checks++; if (o_full !== (model.size() == CAP)) begin
        failures++; $display("FAIL rand_full[%0d] got=%b want=%b", i, o_full, (model.size() == CAP));
      end
      checks++; if (o_empty !== (model.size() == 0)) begin
        failures++; $display("FAIL rand_empty[%0d] got=%b want=%b", i, o_empty, (model.size() == 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_enqueue();
    test_full_ignore();
    test_dequeue();
    test_replace();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
